flags_ctrl: RTL and testbench

- Parametrised successor to the CPU status-register/condition logic.
- Holds NFLAGS ALU flags with per-flag write mask and sticky flags, evaluates the instruction condition into do_exec, and keeps a STACK_DEPTH flag save/restore stack for call/interrupt context.
- Sits between the ALU flag outputs and control decode; replaces the fixed 8-bit czonENGL register and gated flags clock.

---
 rtl/flags_ctrl_if.sv | 32 +++
 rtl/flags_ctrl.sv | 64 ++++++
 tb/tb_flags_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/flags_ctrl_if.sv
// flags_ctrl_if: ALU-flag, condition, stack and error signals between decode/ALU and flags_ctrl.
interface flags_ctrl_if #(
   parameter int NFLAGS      = 8,
   parameter int STACK_DEPTH = 4,
   parameter int CW          = $clog2(NFLAGS + 1) + 1
);
   localparam int DW = $clog2(STACK_DEPTH + 1);
   logic              phase_exec;
   logic [NFLAGS-1:0] alu_flags;
   logic              _set_flags;
   logic [NFLAGS-1:0] wr_mask;
   logic [NFLAGS-1:0] sticky_clr;
   logic [CW-1:0]     cond;
   logic              push;
   logic              pop;
   logic              err_clr;
   logic [NFLAGS-1:0] flags_q;
   logic [NFLAGS-1:0] _flags_q;
   logic              do_exec;
   logic [DW-1:0]     depth;
   logic              overflow;
   logic              underflow;
   logic              illegal_load;
   modport master (
      output phase_exec, alu_flags, _set_flags, wr_mask, sticky_clr, cond, push, pop, err_clr,
      input  flags_q, _flags_q, do_exec, depth, overflow, underflow, illegal_load
   );
   modport slave (
      input  phase_exec, alu_flags, _set_flags, wr_mask, sticky_clr, cond, push, pop, err_clr,
      output flags_q, _flags_q, do_exec, depth, overflow, underflow, illegal_load
   );
endinterface

// File: rtl/flags_ctrl.sv
// flags_ctrl: masked/sticky ALU flag register, condition evaluation and flag save/restore stack.
module flags_ctrl #(
   parameter int                 NFLAGS      = 8,
   parameter int                 STACK_DEPTH = 4,
   parameter logic [NFLAGS-1:0]  STICKY_MASK = '0,
   parameter logic [NFLAGS-1:0]  RESET_VAL   = '0,
   parameter int                 CW          = $clog2(NFLAGS + 1) + 1
) (
   input logic         clk,
   input logic         _reset,
   flags_ctrl_if.slave bus
);
   localparam int DW = $clog2(STACK_DEPTH + 1);
   logic [NFLAGS-1:0] flags, nf, clr;
   logic [NFLAGS:0]   ext;
   logic [CW-2:0]     idx;
   logic [DW-1:0]     depth, top;
   logic              sel, load, full, empty, px, ovf, udf, ill;
   // sized to the full index range so depth indexes it without truncation
   logic [NFLAGS-1:0] stk [2**DW];
   always_comb begin
      idx   = bus.cond[CW-2:0];
      ext   = {flags, 1'b1};
      sel   = (idx <= NFLAGS) ? ext[idx] : 1'b0;
      px    = bus.phase_exec;
      load  = px & ~bus._set_flags & bus.do_exec;
      clr   = px ? (bus.sticky_clr & STICKY_MASK) : '0;
      nf    = (load ? ((flags & ~bus.wr_mask) | (bus.wr_mask & (bus.alu_flags | (flags & STICKY_MASK)))) : flags) & ~clr;
      full  = depth == DW'(STACK_DEPTH);
      empty = depth == '0;
      top   = depth - DW'(1);
   end
   assign bus.do_exec      = bus.cond[CW-1] ^ sel;
   assign bus.flags_q      = flags;
   assign bus._flags_q     = ~flags;
   assign bus.depth        = depth;
   assign bus.overflow     = ovf;
   assign bus.underflow    = udf;
   assign bus.illegal_load = ill;
   always_ff @(posedge clk) begin
      if (!_reset) begin
         flags <= RESET_VAL;
         depth <= '0;
         ovf   <= 1'b0;
         udf   <= 1'b0;
         ill   <= 1'b0;
      end else begin
         ill <= (ill & ~bus.err_clr) | (~px & ~bus._set_flags);
         ovf <= (ovf & ~bus.err_clr) | (px & bus.push & ~bus.pop & full);
         udf <= (udf & ~bus.err_clr) | (px & bus.pop & empty);
         if (px & bus.pop & ~empty) begin
            flags <= stk[top];
            if (bus.push) stk[top] <= flags;
            else depth <= top;
         end else begin
            flags <= nf;
            if (px & bus.push & ~full) begin
               stk[depth] <= flags;
               depth      <= depth + DW'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_flags_ctrl.sv
// tb_flags_ctrl: directed vectors for flags_ctrl with a sticky bit 0 and a two-slot stack.
module tb_flags_ctrl;
   logic clk = 1'b0;
   logic _reset;
   int   n_chk = 0;
   int   n_fail = 0;
   flags_ctrl_if #(.NFLAGS(8), .STACK_DEPTH(2)) bus ();
   flags_ctrl #(.NFLAGS(8), .STACK_DEPTH(2), .STICKY_MASK(8'h01), .RESET_VAL(8'h00)) dut (
      .clk(clk), ._reset(_reset), .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic idle();
      bus.phase_exec = 1'b1;
      bus._set_flags = 1'b1;
      bus.alu_flags  = 8'h00;
      bus.wr_mask    = 8'hFF;
      bus.sticky_clr = 8'h00;
      bus.cond       = 5'h00;
      bus.push       = 1'b0;
      bus.pop        = 1'b0;
      bus.err_clr    = 1'b0;
   endtask
   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask
   task automatic ld(input logic [7:0] v, input logic [7:0] sc);
      bus._set_flags = 1'b0;
      bus.alu_flags  = v;
      bus.sticky_clr = sc;
      step();
   endtask
   initial begin
      idle();
      _reset = 1'b0;
      step();
      check("rst_flags", bus.flags_q, 8'h00);
      check("rst_nflags", bus._flags_q, 8'hFF);
      check("rst_depth", bus.depth, 0);
      check("rst_errs", {bus.overflow, bus.underflow, bus.illegal_load}, 0);
      _reset = 1'b1;
      ld(8'h80, 8'h00);
      check("load80", bus.flags_q, 8'h80);
      bus.cond = 5'h08;
      #1 check("cond_c", bus.do_exec, 1);
      bus.cond = 5'h18;
      #1 check("cond_inv_c", bus.do_exec, 0);
      bus.cond = 5'h09;
      #1 check("cond_oob", bus.do_exec, 0);
      bus.cond = 5'h10;
      #1 check("cond_never", bus.do_exec, 0);
      bus.cond = 5'h00;
      #1 check("cond_always", bus.do_exec, 1);
      ld(8'h00, 8'h00);
      check("load00", bus.flags_q, 8'h00);
      bus.cond = 5'h08;
      ld(8'hFF, 8'h00);
      check("skip_load", bus.flags_q, 8'h00);
      ld(8'hFF, 8'h00);
      check("cond0_load", bus.flags_q, 8'hFF);
      ld(8'h01, 8'h00);
      check("load01", bus.flags_q, 8'h01);
      ld(8'h00, 8'h00);
      check("sticky_hold", bus.flags_q, 8'h01);
      bus.wr_mask = 8'h0F;
      ld(8'hF0, 8'h00);
      check("mask_hold", bus.flags_q, 8'h01);
      bus.sticky_clr = 8'h01;
      step();
      check("sticky_clr", bus.flags_q, 8'h00);
      bus.phase_exec = 1'b0;
      ld(8'h00, 8'h00);
      ld(8'h01, 8'h00);
      check("sticky_or", bus.flags_q, 8'h01);
      ld(8'h01, 8'h01);
      check("clr_prio", bus.flags_q, 8'h00);
      ld(8'hA5, 8'h00);
      bus.push = 1'b1;
      step();
      check("push1_depth", bus.depth, 1);
      ld(8'h5A, 8'h01);
      check("load5A", bus.flags_q, 8'h5A);
      bus.push = 1'b1;
      step();
      check("push2_depth", bus.depth, 2);
      bus.push = 1'b1;
      step();
      check("ovf", bus.overflow, 1);
      check("ovf_depth", bus.depth, 2);
      ld(8'h00, 8'h00);
      check("clear_before_pop", bus.flags_q, 8'h00);
      bus.pop = 1'b1;
      step();
      check("pop1", bus.flags_q, 8'h5A);
      bus.pop = 1'b1;
      step();
      check("pop2", bus.flags_q, 8'hA5);
      check("pop2_depth", bus.depth, 0);
      bus.pop = 1'b1;
      step();
      check("udf", bus.underflow, 1);
      check("udf_flags", bus.flags_q, 8'hA5);
      bus.err_clr = 1'b1;
      step();
      check("err_clr", {bus.overflow, bus.underflow}, 0);
      ld(8'h3C, 8'h01);
      bus.push = 1'b1;
      step();
      ld(8'hC3, 8'h00);
      check("loadC3", bus.flags_q, 8'hC3);
      bus.push = 1'b1;
      bus.pop  = 1'b1;
      step();
      check("xchg_flags", bus.flags_q, 8'h3C);
      check("xchg_depth", bus.depth, 1);
      bus.pop = 1'b1;
      step();
      check("xchg_slot", bus.flags_q, 8'hC3);
      bus.phase_exec = 1'b0;
      bus.push = 1'b1;
      ld(8'hFF, 8'h00);
      check("illegal", bus.illegal_load, 1);
      check("illegal_flags", bus.flags_q, 8'hC3);
      check("oop_push", bus.depth, 0);
      bus.phase_exec = 1'b0;
      bus.err_clr = 1'b1;
      ld(8'hFF, 8'h00);
      check("set_beats_clr", bus.illegal_load, 1);
      bus.err_clr = 1'b1;
      step();
      check("ill_cleared", bus.illegal_load, 0);
      bus.push = 1'b1;
      bus.pop  = 1'b1;
      step();
      check("xchg_empty_udf", bus.underflow, 1);
      check("xchg_empty_depth", bus.depth, 1);
      bus.push = 1'b1;
      _reset = 1'b0;
      step();
      check("mid_rst_depth", bus.depth, 0);
      check("mid_rst_flags", bus.flags_q, 8'h00);
      check("mid_rst_errs", {bus.overflow, bus.underflow, bus.illegal_load}, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
